// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module   : md_unit
// Purpose  : Iterative multiply/divide unit owning HI/LO; one bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_result
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_a_raw;
    logic             r_neg_lo;
    logic             r_neg_hi;
    logic             r_divz;

    logic             w_signed;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH-1:0] w_mul_q;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [WIDTH:0]   w_div_sh;
    logic [WIDTH:0]   w_div_diff;
    logic             w_div_ok;
    logic [WIDTH-1:0] w_div_acc;
    logic [WIDTH-1:0] w_div_q;
    logic [WIDTH-1:0] w_quo_s;
    logic [WIDTH-1:0] w_rem_s;

    assign md_result = md_control[0] ? lo : hi;

    // Even opcodes (mult, div) are the signed variants.
    assign w_signed = ~md_control[0];
    assign w_a_neg  = w_signed & a[WIDTH-1];
    assign w_b_neg  = w_signed & b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    // Shift-add: r_acc holds the running upper half, r_q the multiplier/low half.
    assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opb} : '0);
    assign w_mul_acc = w_mul_sum[WIDTH:1];
    assign w_mul_q   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    assign w_prod    = {w_mul_acc, w_mul_q};
    assign w_prod_s  = r_neg_lo ? -w_prod : w_prod;

    // Restoring division: r_acc is the partial remainder, r_q shifts dividend out / quotient in.
    assign w_div_sh   = {r_acc, r_q[WIDTH-1]};
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_div_ok   = ~w_div_diff[WIDTH];
    assign w_div_acc  = w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
    assign w_div_q    = {r_q[WIDTH-2:0], w_div_ok};
    assign w_quo_s    = r_neg_lo ? -w_div_q : w_div_q;
    assign w_rem_s    = r_neg_hi ? -w_div_acc : w_div_acc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_opb    <= '0;
            r_a_raw  <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_divz   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        case (md_control)
                            3'b000, 3'b001: begin
                                r_state  <= S_MUL;
                                r_count  <= '0;
                                r_acc    <= '0;
                                r_q      <= w_b_mag;
                                r_opb    <= w_a_mag;
                                r_neg_lo <= w_a_neg ^ w_b_neg;
                                busy     <= 1'b1;
                            end
                            3'b010, 3'b011: begin
                                r_state  <= S_DIV;
                                r_count  <= '0;
                                r_acc    <= '0;
                                r_q      <= w_a_mag;
                                r_opb    <= w_b_mag;
                                r_neg_lo <= w_a_neg ^ w_b_neg;
                                r_neg_hi <= w_a_neg;
                                r_divz   <= (b == '0);
                                r_a_raw  <= a;
                                busy     <= 1'b1;
                            end
                            3'b100:  hi <= a;
                            3'b101:  lo <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc   <= w_mul_acc;
                    r_q     <= w_mul_q;
                    r_count <= r_count + C_ONE;
                    if (r_count == C_LAST) begin
                        hi      <= w_prod_s[2*WIDTH-1:WIDTH];
                        lo      <= w_prod_s[WIDTH-1:0];
                        r_state <= S_IDLE;
                        r_count <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_acc   <= w_div_acc;
                    r_q     <= w_div_q;
                    r_count <= r_count + C_ONE;
                    if (r_count == C_LAST) begin
                        // Divide by zero returns the dividend untouched in HI.
                        if (r_divz) begin
                            hi <= r_a_raw;
                            lo <= '1;
                        end else begin
                            hi <= w_rem_s;
                            lo <= w_quo_s;
                        end
                        r_state <= S_IDLE;
                        r_count <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_unit
// Purpose  : Directed self-checking bench for md_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  md_control = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_result;

    int checks   = 0;
    int failures = 0;

    md_unit #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .md_control (md_control),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .md_result  (md_result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents one request for exactly one sampling edge, then scrambles operands.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        md_control = op;
        a          = av;
        b          = bv;
        start      = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] want_hi, input logic [31:0] want_lo,
                          input int inject);
        int n;
        issue(op, av, bv);
        chk({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
            if (n == inject) begin
                md_control = 3'b000;
                a          = 32'd3;
                b          = 32'd5;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, "_cycles"}, n, 32'd32);
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_hi"}, hi, want_hi);
        chk({tag, "_lo"}, lo, want_lo);
        tick();
        chk({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_result", md_result, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        run_md("mult",  3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_md("multu", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_md("div",   3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_md("divz",  3'b011, 32'd100,      32'd0,        32'h00000064, 32'hFFFFFFFF, 0);
        run_md("divov", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);

        issue(3'b100, 32'h12345678, 32'd0);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'b101, 32'h9ABCDEF0, 32'd0);
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", hi, 32'h12345678);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        md_control = 3'b110;
        #1;
        chk("mfhi", md_result, 32'h12345678);
        md_control = 3'b111;
        #1;
        chk("mflo", md_result, 32'h9ABCDEF0);

        // A mult request mid-divide must not disturb 100/7.
        run_md("divu_ign", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10);

        issue(3'b000, 32'd123, 32'd456);
        repeat (14) tick();
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        tick();

        run_md("mult_post", 3'b000, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'h00000000, 32'h0000001E, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
